// File: rtl/trigger_controller.sv
// rtl/trigger_controller.sv - triggered frame capture sequencer for the sample buffers
// Writes PRE pre-trigger samples plus the post-trigger tail into a circular buffer, then freezes it.
module trigger_controller #(
    parameter int DATA_W     = 12,
    parameter int DEPTH      = 640,
    parameter int ADDR_W     = 10,
    parameter int PRE        = 320,
    parameter int HOLDOFF    = 4,
    parameter int AUTO_TICKS = 2048
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sampleTick,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] trigLevel,
    input  logic              trigSlope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic              hold,
    output logic              writeEn,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] writeData,
    output logic [ADDR_W-1:0] startAddr,
    output logic              frameDone,
    output logic              trigd,
    output logic              autoFired,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRETRIG = 3'd1,
        S_ARMED   = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int HOLD_W = $clog2(HOLDOFF + 2);
    localparam int AUTO_W = $clog2(AUTO_TICKS + 1);
    localparam int POST_N = DEPTH - PRE - 1;

    localparam logic [CNT_W-1:0]  PRE_LAST   = CNT_W'(PRE - 1);
    localparam logic [CNT_W-1:0]  POST_LAST  = CNT_W'((POST_N > 0) ? POST_N - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [AUTO_W-1:0] AUTO_MAX   = AUTO_W'(AUTO_TICKS);
    localparam logic [ADDR_W-1:0] DEPTH_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_A      = ADDR_W'(PRE);
    localparam logic [ADDR_W-1:0] WRAP_ADD   = ADDR_W'(DEPTH - PRE);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]    post_cnt_q, post_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [AUTO_W-1:0]   auto_cnt_q, auto_cnt_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic                write_en_q, write_en_d;
    logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
    logic                frame_done_q, frame_done_d;
    logic                trigd_q, trigd_d;
    logic                auto_fired_q, auto_fired_d;

    logic                do_write;
    logic                finish_frame;
    logic [ADDR_W-1:0]   frame_trig_addr;
    logic                rise_hit, fall_hit, level_hit, auto_force;

    assign rise_hit   = (prev_q < trigLevel) && (data >= trigLevel);
    assign fall_hit   = (prev_q > trigLevel) && (data <= trigLevel);
    assign level_hit  = trigSlope ? fall_hit : rise_hit;
    assign auto_force = mode[0] && (auto_cnt_q == AUTO_MAX);

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        pre_cnt_d       = pre_cnt_q;
        post_cnt_d      = post_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        auto_cnt_d      = auto_cnt_q;
        prev_d          = prev_q;
        trig_addr_d     = trig_addr_q;
        write_en_d      = 1'b0;
        write_addr_d    = write_addr_q;
        write_data_d    = write_data_q;
        start_addr_d    = start_addr_q;
        frame_done_d    = 1'b0;
        trigd_d         = 1'b0;
        auto_fired_d    = auto_fired_q;
        do_write        = 1'b0;
        finish_frame    = 1'b0;
        frame_trig_addr = trig_addr_q;

        case (state_q)
            S_IDLE: begin
                // Leaving IDLE does not wait for a tick so a one-clock arm is never missed.
                if (mode != 2'b10 || arm) begin
                    state_d   = S_PRETRIG;
                    pre_cnt_d = '0;
                end
            end
            S_PRETRIG: begin
                if (sampleTick) begin
                    do_write = 1'b1;
                    if (pre_cnt_q == PRE_LAST) begin
                        state_d    = S_ARMED;
                        auto_cnt_d = '0;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (sampleTick) begin
                    do_write = 1'b1;
                    if (level_hit || auto_force) begin
                        trig_addr_d     = ptr_q;
                        frame_trig_addr = ptr_q;
                        trigd_d         = 1'b1;
                        auto_fired_d    = !level_hit;
                        post_cnt_d      = '0;
                        if (POST_N == 0) begin
                            finish_frame = 1'b1;
                        end else begin
                            state_d = S_CAPTURE;
                        end
                    end else if (auto_cnt_q != AUTO_MAX) begin
                        auto_cnt_d = auto_cnt_q + 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (sampleTick) begin
                    do_write = 1'b1;
                    if (post_cnt_q == POST_LAST) begin
                        finish_frame = 1'b1;
                    end else begin
                        post_cnt_d = post_cnt_q + 1'b1;
                    end
                end
            end
            S_HOLDOFF: begin
                if (sampleTick && !hold) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d   = (mode == 2'b10) ? S_IDLE : S_PRETRIG;
                        pre_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_write) begin
            write_en_d   = 1'b1;
            write_addr_d = ptr_q;
            write_data_d = data;
            prev_d       = data;
            ptr_d        = (ptr_q == DEPTH_LAST) ? '0 : ptr_q + 1'b1;
        end

        // Oldest sample sits PRE slots behind the trigger, wrapping modulo DEPTH.
        if (finish_frame) begin
            start_addr_d = (frame_trig_addr >= PRE_A) ? frame_trig_addr - PRE_A
                                                      : frame_trig_addr + WRAP_ADD;
            frame_done_d = 1'b1;
            state_d      = S_HOLDOFF;
            hold_cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            auto_cnt_q   <= '0;
            prev_q       <= '0;
            trig_addr_q  <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            start_addr_q <= '0;
            frame_done_q <= 1'b0;
            trigd_q      <= 1'b0;
            auto_fired_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            auto_cnt_q   <= auto_cnt_d;
            prev_q       <= prev_d;
            trig_addr_q  <= trig_addr_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            start_addr_q <= start_addr_d;
            frame_done_q <= frame_done_d;
            trigd_q      <= trigd_d;
            auto_fired_q <= auto_fired_d;
        end
    end

    assign writeEn   = write_en_q;
    assign writeAddr = write_addr_q;
    assign writeData = write_data_q;
    assign startAddr = start_addr_q;
    assign frameDone = frame_done_q;
    assign trigd     = trigd_q;
    assign autoFired = auto_fired_q;
    assign state     = state_q;

endmodule
